// File: rtl/l2_adaptor_pkg.sv
// l2_adaptor_pkg
// Shared constants, FSM state type, beat index type and the line-alignment
// helper for the L2 line adaptor (256-bit line <-> 4 x 64-bit memory burst).
// No ports.
package l2_adaptor_pkg;

  localparam int unsigned BEATS       = 4;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned LINE_W      = 256;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFFSET_BITS = 5;

  typedef logic [1:0] beat_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StRdBurst,
    StRdDone,
    StWrBurst,
    StWrDone
  } state_e;

  // Clear the byte offset within a 32-byte line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_line_adaptor_if.sv
// l2_line_adaptor_if
// Bundles the L2-side line signals and the memory-side burst signals of the
// line adaptor.
//   slave  : adaptor view (takes L2 requests and memory beats, drives line,
//            completion, burst data, address and memory requests)
//   master : environment view (L2 control/datapath plus memory), the reverse
// Signals:
//   line_i/line_o (256), address_i/address_o (32), read_i, write_i, resp_o,
//   burst_i/burst_o (64), read_o, write_o, resp_i
interface l2_line_adaptor_if;
  import l2_adaptor_pkg::*;

  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i;
  logic [ADDR_W-1:0] address_o;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, address_o, resp_o, burst_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, address_o, resp_o, burst_o, read_o, write_o
  );

endinterface

// File: rtl/l2_beat_buffer.sv
// l2_beat_buffer
// 256-bit line register viewed as 4 x 64-bit beats.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears the line)
//   i_line_we    : load the whole line from i_line (has priority)
//   i_line       : full line to load
//   i_beat_we    : load beat i_idx from i_beat
//   i_idx        : beat index for load and output mux
//   i_beat       : beat to load
//   o_line       : registered line
//   o_beat       : beat selected by i_idx
module l2_beat_buffer
  import l2_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_line_we,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_beat_we,
  input  beat_idx_t         i_idx,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [LINE_W-1:0] o_line,
  output logic [BEAT_W-1:0] o_beat
);

  logic [BEATS-1:0][BEAT_W-1:0] r_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line <= '0;
    end else if (i_line_we) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      r_line[i_idx] <= i_beat;
    end
  end

  assign o_line = r_line;
  assign o_beat = r_line[i_idx];

endmodule

// File: rtl/l2_line_adaptor.sv
// l2_line_adaptor
// Memory-side end of the L2 line path. A refill collects four 64-bit beats
// into a 256-bit line; a write-back serialises a 256-bit victim line into
// four beats. Beats advance only on resp_i, so memory may stall freely.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : l2_line_adaptor_if.slave (L2 request/line + memory burst)
//   err_o      : sticky protocol-error flag, present only when the macro
//                L2_ADAPTOR_ERR_EN is defined
// Separate read and write buffers let line_o hold the last refill across
// intervening write-backs.
module l2_line_adaptor
  import l2_adaptor_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
`ifdef L2_ADAPTOR_ERR_EN
  output logic                   err_o,
`endif
  l2_line_adaptor_if.slave       bus
);

  state_e            r_state;
  state_e            w_state_d;
  beat_idx_t         r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic              w_last_beat;
  logic              w_accept;
  logic              w_rd_beat_we;
  logic              w_wr_line_we;
  logic [BEAT_W-1:0] w_wr_beat;
  logic [LINE_W-1:0] w_rd_line;
  logic [BEAT_W-1:0] w_rd_beat_unused;
  logic [LINE_W-1:0] w_wr_line_unused;
  logic              w_read_o;
  logic              w_write_o;
  logic              w_resp_o;
  logic [BEAT_W-1:0] w_burst_o;

  assign w_last_beat  = (r_beat == beat_idx_t'(BEATS - 1));
  assign w_accept     = (r_state == StIdle) && (bus.read_i || bus.write_i);
  assign w_wr_line_we = (r_state == StIdle) && bus.write_i;
  assign w_rd_beat_we = (r_state == StRdBurst) && bus.resp_i;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; write wins over a simultaneous read
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.write_i) begin
          w_state_d = StWrBurst;
        end else if (bus.read_i) begin
          w_state_d = StRdBurst;
        end
      end
      StRdBurst: if (bus.resp_i && w_last_beat) w_state_d = StRdDone;
      StWrBurst: if (bus.resp_i && w_last_beat) w_state_d = StWrDone;
      StRdDone:  w_state_d = StIdle;
      StWrDone:  w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    w_read_o  = (r_state == StRdBurst);
    w_write_o = (r_state == StWrBurst);
    w_resp_o  = (r_state == StRdDone) || (r_state == StWrDone);
    w_burst_o = '0;
    if (r_state == StWrBurst) begin
      w_burst_o = w_wr_beat;
    end
  end

  // Beat counter is held at 0 in idle, so every burst starts from beat 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat <= '0;
    end else if (r_state == StIdle) begin
      r_beat <= '0;
    end else if (((r_state == StRdBurst) || (r_state == StWrBurst)) && bus.resp_i) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= line_align(bus.address_i);
    end
  end

  l2_beat_buffer u_rd_buf (
    .clk       (clk),
    .reset     (reset),
    .i_line_we (1'b0),
    .i_line    ('0),
    .i_beat_we (w_rd_beat_we),
    .i_idx     (r_beat),
    .i_beat    (bus.burst_i),
    .o_line    (w_rd_line),
    .o_beat    (w_rd_beat_unused)
  );

  l2_beat_buffer u_wr_buf (
    .clk       (clk),
    .reset     (reset),
    .i_line_we (w_wr_line_we),
    .i_line    (bus.line_i),
    .i_beat_we (1'b0),
    .i_idx     (r_beat),
    .i_beat    ('0),
    .o_line    (w_wr_line_unused),
    .o_beat    (w_wr_beat)
  );

  assign bus.line_o    = w_rd_line;
  assign bus.address_o = r_addr;
  assign bus.read_o    = w_read_o;
  assign bus.write_o   = w_write_o;
  assign bus.resp_o    = w_resp_o;
  assign bus.burst_o   = w_burst_o;

`ifdef L2_ADAPTOR_ERR_EN
  logic r_err;
  logic w_err_set;

  // Ack outside a burst, or colliding read/write requests
  assign w_err_set = (bus.resp_i && ((r_state == StIdle) || (r_state == StRdDone) ||
                                     (r_state == StWrDone))) ||
                     ((r_state == StIdle) && bus.read_i && bus.write_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_l2_line_adaptor.sv
// tb_l2_line_adaptor
// Directed bench for l2_line_adaptor: refill, write-back with stalls,
// simultaneous requests, reset mid-refill, spurious acks, back-to-back
// write then read. Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point.
module tb_l2_line_adaptor;

  logic clk = 1'b0;
  logic reset;
`ifdef L2_ADAPTOR_ERR_EN
  logic err_o;
`endif

  int checks = 0;
  int errors = 0;
  int pulses;

  l2_line_adaptor_if bus ();

  l2_line_adaptor u_dut (
    .clk   (clk),
    .reset (reset),
`ifdef L2_ADAPTOR_ERR_EN
    .err_o (err_o),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] Junk = 64'hDEAD_BEEF_DEAD_BEEF;

  logic [63:0]  rf_beats [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [255:0] rf_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  logic [255:0] wr_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  logic         wr_ack [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0]  wr_exp [7] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                               64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
                               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD,
                               64'hDDDD_DDDD_DDDD_DDDD};

  logic         nr_ack  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0]  nr_data [6] = '{64'h0123_4567_89AB_CDEF, Junk, 64'hFEDC_BA98_7654_3210,
                                64'h0F0F_0F0F_F0F0_F0F0, Junk, 64'hA5A5_5A5A_C3C3_3C3C};
  logic [255:0] nr_line = {64'hA5A5_5A5A_C3C3_3C3C, 64'h0F0F_0F0F_F0F0_F0F0,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

  logic [63:0]  bb_w [4] = '{64'h5555_0000_5555_0000, 64'h6666_0000_6666_0000,
                             64'h7777_0000_7777_0000, 64'h8888_0000_8888_0000};
  logic [63:0]  bb_r [4] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
                             64'h0000_0000_0000_0003, 64'h8000_0000_0000_0004};
  logic [255:0] bb_rline = {64'h8000_0000_0000_0004, 64'h0000_0000_0000_0003,
                            64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_line_o", bus.line_o, 256'd0);
    check("rst_burst_o", 256'(bus.burst_o), 256'd0);
    check("rst_address_o", 256'(bus.address_o), 256'd0);
    check("rst_read_o", 256'(bus.read_o), 256'd0);
    check("rst_write_o", 256'(bus.write_o), 256'd0);
    check("rst_resp_o", 256'(bus.resp_o), 256'd0);
`ifdef L2_ADAPTOR_ERR_EN
    check("rst_err_o", 256'(err_o), 256'd0);
`endif

    // Refill, back-to-back beats. Request cycle + accept, 4 beats -> resp_o
    // visible in the 6th cycle counting the request cycle.
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    tick();
    bus.read_i    = 1'b0;
    bus.address_i = 32'hFFFF_FFFF;
    check("rf_address_o", 256'(bus.address_o), 256'h0000_1220);
    check("rf_read_o_on", 256'(bus.read_o), 256'd1);
    for (int i = 0; i < 4; i++) begin
      check("rf_resp_o_early", 256'(bus.resp_o), 256'd0);
      bus.burst_i = rf_beats[i];
      bus.resp_i  = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    check("rf_resp_o_pulse", 256'(bus.resp_o), 256'd1);
    check("rf_read_o_off", 256'(bus.read_o), 256'd0);
    check("rf_line_o", bus.line_o, rf_line);
    tick();
    check("rf_resp_o_one_cycle", 256'(bus.resp_o), 256'd0);

    // Write-back with stalls
    bus.line_i    = wr_line;
    bus.address_i = 32'h0000_3F7F;
    bus.write_i   = 1'b1;
    tick();
    bus.write_i = 1'b0;
    bus.line_i  = '0;
    check("wr_address_o", 256'(bus.address_o), 256'h0000_3F60);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      check("wr_burst_o", 256'(bus.burst_o), 256'(wr_exp[i]));
      check("wr_write_o_on", 256'(bus.write_o), 256'd1);
      bus.resp_i = wr_ack[i];
      tick();
      if (bus.resp_o) pulses++;
    end
    bus.resp_i = 1'b0;
    check("wr_write_o_off", 256'(bus.write_o), 256'd0);
    tick();
    if (bus.resp_o) pulses++;
    check("wr_resp_pulses", 256'(pulses), 256'd1);
    check("wr_line_o_held", bus.line_o, rf_line);
`ifdef L2_ADAPTOR_ERR_EN
    check("wr_err_o_clean", 256'(err_o), 256'd0);
`endif

    // Simultaneous read and write: write only
    bus.line_i    = {4{64'h9999_9999_9999_9999}};
    bus.address_i = 32'h0000_0040;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    tick();
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    check("sim_write_o", 256'(bus.write_o), 256'd1);
    for (int i = 0; i < 4; i++) begin
      check("sim_read_o", 256'(bus.read_o), 256'd0);
      check("sim_burst_o", 256'(bus.burst_o), 256'(64'h9999_9999_9999_9999));
      bus.resp_i = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    check("sim_resp_o", 256'(bus.resp_o), 256'd1);
    tick();
    check("sim_line_o_held", bus.line_o, rf_line);
`ifdef L2_ADAPTOR_ERR_EN
    check("sim_err_o", 256'(err_o), 256'd1);
`endif

    // Reset after two refill beats
    bus.address_i = 32'h8000_0047;
    bus.read_i    = 1'b1;
    tick();
    bus.read_i = 1'b0;
    check("mr_address_o", 256'(bus.address_o), 256'h8000_0040);
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h5555_5555_5555_5555;
    tick();
    bus.burst_i = 64'h6666_6666_6666_6666;
    tick();
    check("mr_partial_line", bus.line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                          64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    reset       = 1'b1;
    bus.burst_i = 64'h7777_7777_7777_7777;
    tick();
    reset      = 1'b0;
    bus.resp_i = 1'b0;
    check("mr_read_o", 256'(bus.read_o), 256'd0);
    check("mr_line_o", bus.line_o, 256'd0);
    check("mr_resp_o", 256'(bus.resp_o), 256'd0);
    check("mr_address_o_clr", 256'(bus.address_o), 256'd0);
`ifdef L2_ADAPTOR_ERR_EN
    check("mr_err_o_clr", 256'(err_o), 256'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_resp", 256'(bus.resp_o), 256'd0);
      check("mr_idle_read_o", 256'(bus.read_o), 256'd0);
    end

    // Fresh refill with stalls after the reset
    bus.address_i = 32'h0000_ABCD;
    bus.read_i    = 1'b1;
    tick();
    bus.read_i = 1'b0;
    check("nr_address_o", 256'(bus.address_o), 256'h0000_ABC0);
    for (int i = 0; i < 6; i++) begin
      check("nr_resp_o_early", 256'(bus.resp_o), 256'd0);
      bus.burst_i = nr_data[i];
      bus.resp_i  = nr_ack[i];
      tick();
    end
    bus.resp_i = 1'b0;
    check("nr_resp_o", 256'(bus.resp_o), 256'd1);
    check("nr_line_o", bus.line_o, nr_line);
    tick();

    // Spurious acks in idle
    bus.burst_i = Junk;
    bus.resp_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sp_resp_o", 256'(bus.resp_o), 256'd0);
      check("sp_read_o", 256'(bus.read_o), 256'd0);
      check("sp_line_o", bus.line_o, nr_line);
    end
    bus.resp_i = 1'b0;
`ifdef L2_ADAPTOR_ERR_EN
    check("sp_err_o", 256'(err_o), 256'd1);
`endif

    // Write-back followed by a read issued after the write's resp_o
    bus.line_i    = {bb_w[3], bb_w[2], bb_w[1], bb_w[0]};
    bus.address_i = 32'h0000_0100;
    bus.write_i   = 1'b1;
    tick();
    bus.write_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bb_burst_o", 256'(bus.burst_o), 256'(bb_w[i]));
      bus.resp_i = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    check("bb_wr_resp_o", 256'(bus.resp_o), 256'd1);
    bus.address_i = 32'h0000_2468;
    bus.read_i    = 1'b1;
    tick();
    check("bb_done_read_o", 256'(bus.read_o), 256'd0);
    check("bb_done_resp_o", 256'(bus.resp_o), 256'd0);
    tick();
    bus.read_i = 1'b0;
    check("bb_read_o", 256'(bus.read_o), 256'd1);
    check("bb_address_o", 256'(bus.address_o), 256'h0000_2460);
    for (int i = 0; i < 4; i++) begin
      bus.burst_i = bb_r[i];
      bus.resp_i  = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    check("bb_rd_resp_o", 256'(bus.resp_o), 256'd1);
    check("bb_line_o", bus.line_o, bb_rline);
    tick();
    check("bb_idle_resp_o", 256'(bus.resp_o), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
